// File: rtl/cmd_rd53_pkg.sv
// Shared RD53 command-stream constants and trigger symbol lookup,
// used by both the command transmitter and the receiver.
package cmd_rd53_pkg;

  localparam logic [15:0] SYNC_PATTERN = 16'h817E;
  localparam logic [7:0]  TAG_PATTERN  = 8'h6A;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_e;

  // Returns the trigger index 1..15 for a trigger symbol, 0 for any other byte.
  function automatic logic [3:0] trig_symbol_index(input logic [7:0] sym);
    logic [3:0] idx;
    idx = 4'd0;
    case (sym)
      8'h2B: idx = 4'd1;
      8'h2D: idx = 4'd2;
      8'h2E: idx = 4'd3;
      8'h33: idx = 4'd4;
      8'h35: idx = 4'd5;
      8'h36: idx = 4'd6;
      8'h39: idx = 4'd7;
      8'h3A: idx = 4'd8;
      8'h3C: idx = 4'd9;
      8'h4B: idx = 4'd10;
      8'h4D: idx = 4'd11;
      8'h4E: idx = 4'd12;
      8'h53: idx = 4'd13;
      8'h55: idx = 4'd14;
      8'h56: idx = 4'd15;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/cmd_rd53_frame_decode.sv
// Combinational classifier for one aligned 16-bit command frame.
module cmd_rd53_frame_decode
  import cmd_rd53_pkg::*;
(
  input  logic [15:0] frame,
  output logic        is_sync,
  output logic        is_trig,
  output logic [3:0]  trig_idx,
  output logic        is_tag_err
);

  logic [3:0] idx;

  always_comb begin
    idx        = trig_symbol_index(frame[15:8]);
    is_sync    = (frame == SYNC_PATTERN);
    is_trig    = (idx != 4'd0) && (frame[7:0] == TAG_PATTERN);
    is_tag_err = (idx != 4'd0) && (frame[7:0] != TAG_PATTERN);
    trig_idx   = idx;
  end

endmodule

// File: rtl/cmd_rd53_rx.sv
// RD53 command receiver: serial deserializer, sync alignment FSM, frame
// decode strobes and saturating event counters, all in the CMD_CLK domain.
module cmd_rd53_rx
  import cmd_rd53_pkg::*;
#(
  parameter int LOCK_SYNCS     = 4,
  parameter int MISALIGN_LIMIT = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 CMD_CLK,
  input  logic                 RST,
  input  logic                 CNT_CLEAR,
  input  logic                 CMD_EN,
  input  logic                 CMD_SERIAL_IN,
  output logic                 LOCKED,
  output logic                 SYNC_STROBE,
  output logic                 TRIG_VALID,
  output logic [3:0]           TRIG_INDEX,
  output logic                 DATA_VALID,
  output logic [15:0]          DATA_WORD,
  output logic                 TRIG_ERR,
  output logic [CNT_WIDTH-1:0] SYNC_COUNT,
  output logic [CNT_WIDTH-1:0] TRIG_COUNT,
  output logic [CNT_WIDTH-1:0] DATA_COUNT,
  output logic [CNT_WIDTH-1:0] ERR_COUNT,
  output rx_state_e            STATE_DBG
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_SYNCS);
  localparam logic [3:0] MIS_N  = 4'(MISALIGN_LIMIT);

  rx_state_e   state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  aligned_q, aligned_d;
  logic [3:0]  misalign_q, misalign_d;
  logic        locked_q, locked_d;
  logic        sync_stb_q, sync_stb_d;
  logic        trig_valid_q, trig_valid_d;
  logic [3:0]  trig_index_q, trig_index_d;
  logic        data_valid_q, data_valid_d;
  logic [15:0] data_word_q, data_word_d;
  logic        trig_err_q, trig_err_d;
  logic [CNT_WIDTH-1:0] sync_cnt_q, sync_cnt_d, trig_cnt_q, trig_cnt_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d, err_cnt_q, err_cnt_d;
  logic        boundary;
  logic        dec_sync, dec_trig, dec_err;
  logic [3:0]  dec_idx;

  // Decoding looks at the register value including the bit being sampled,
  // so strobes register on the same edge that takes the frame's last bit.
  cmd_rd53_frame_decode u_decode (
    .frame      (sr_d),
    .is_sync    (dec_sync),
    .is_trig    (dec_trig),
    .trig_idx   (dec_idx),
    .is_tag_err (dec_err)
  );

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] c,
                                                    input logic inc, input logic clr);
    logic [CNT_WIDTH-1:0] n;
    n = c;
    if (clr) n = '0;
    else if (inc && (c != '1)) n = c + 1'b1;
    return n;
  endfunction

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    aligned_d    = aligned_q;
    misalign_d   = misalign_q;
    sync_stb_d   = 1'b0;
    trig_valid_d = 1'b0;
    trig_index_d = trig_index_q;
    data_valid_d = 1'b0;
    data_word_d  = data_word_q;
    trig_err_d   = 1'b0;
    boundary     = 1'b0;

    if (!CMD_EN) begin
      state_d    = ST_HUNT;
      bit_cnt_d  = 4'd0;
      aligned_d  = 4'd0;
      misalign_d = 4'd0;
    end else begin
      sr_d     = {sr_q[14:0], CMD_SERIAL_IN};
      boundary = (bit_cnt_q == 4'd15);
      case (state_q)
        ST_HUNT: begin
          bit_cnt_d  = 4'd0;
          aligned_d  = 4'd0;
          misalign_d = 4'd0;
          if (dec_sync) begin
            aligned_d = 4'd1;
            state_d   = (LOCK_N == 4'd1) ? ST_LOCKED : ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          bit_cnt_d  = bit_cnt_q + 4'd1;
          misalign_d = 4'd0;
          if (boundary) begin
            if (dec_sync) begin
              aligned_d = aligned_q + 4'd1;
              if (aligned_d == LOCK_N) state_d = ST_LOCKED;
            end else begin
              aligned_d = 4'd0;
              state_d   = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (boundary) begin
            if (dec_sync) begin
              sync_stb_d = 1'b1;
              misalign_d = 4'd0;
            end else if (dec_trig) begin
              trig_valid_d = 1'b1;
              trig_index_d = dec_idx;
            end else if (dec_err) begin
              trig_err_d = 1'b1;
            end else begin
              data_valid_d = 1'b1;
              data_word_d  = sr_d;
            end
          end else if (dec_sync) begin
            // A sync pattern off the frame grid means the transmitter slipped.
            misalign_d = misalign_q + 4'd1;
            if (misalign_d == MIS_N) begin
              state_d    = ST_HUNT;
              misalign_d = 4'd0;
              aligned_d  = 4'd0;
              bit_cnt_d  = 4'd0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d   = (state_d == ST_LOCKED);
    sync_cnt_d = sat_cnt(sync_cnt_q, sync_stb_d, CNT_CLEAR);
    trig_cnt_d = sat_cnt(trig_cnt_q, trig_valid_d, CNT_CLEAR);
    data_cnt_d = sat_cnt(data_cnt_q, data_valid_d, CNT_CLEAR);
    err_cnt_d  = sat_cnt(err_cnt_q, trig_err_d, CNT_CLEAR);
  end

  always_ff @(posedge CMD_CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_HUNT;
      sr_q         <= 16'd0;
      bit_cnt_q    <= 4'd0;
      aligned_q    <= 4'd0;
      misalign_q   <= 4'd0;
      locked_q     <= 1'b0;
      sync_stb_q   <= 1'b0;
      trig_valid_q <= 1'b0;
      trig_index_q <= 4'd0;
      data_valid_q <= 1'b0;
      data_word_q  <= 16'd0;
      trig_err_q   <= 1'b0;
      sync_cnt_q   <= '0;
      trig_cnt_q   <= '0;
      data_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      aligned_q    <= aligned_d;
      misalign_q   <= misalign_d;
      locked_q     <= locked_d;
      sync_stb_q   <= sync_stb_d;
      trig_valid_q <= trig_valid_d;
      trig_index_q <= trig_index_d;
      data_valid_q <= data_valid_d;
      data_word_q  <= data_word_d;
      trig_err_q   <= trig_err_d;
      sync_cnt_q   <= sync_cnt_d;
      trig_cnt_q   <= trig_cnt_d;
      data_cnt_q   <= data_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Strobe outputs are single-cycle pulses with no back-pressure; the
  // accompanying TRIG_INDEX / DATA_WORD hold until their next pulse.
  assign LOCKED      = locked_q;
  assign SYNC_STROBE = sync_stb_q;
  assign TRIG_VALID  = trig_valid_q;
  assign TRIG_INDEX  = trig_index_q;
  assign DATA_VALID  = data_valid_q;
  assign DATA_WORD   = data_word_q;
  assign TRIG_ERR    = trig_err_q;
  assign SYNC_COUNT  = sync_cnt_q;
  assign TRIG_COUNT  = trig_cnt_q;
  assign DATA_COUNT  = data_cnt_q;
  assign ERR_COUNT   = err_cnt_q;
  assign STATE_DBG   = state_q;

endmodule

// File: doc/cmd_rd53_rx.md
Name: cmd_rd53_rx

Overview:
Receiver and decoder for the RD53 serial command stream produced by the command transmitter. Deserializes CMD_SERIAL_IN MSB first and aligns to the 16-bit sync symbol 0x817E. Classifies each aligned 16-bit frame as sync, trigger ({trigger symbol, tag 0x6A}) or data. Used in the FPGA as a loopback checker and chip emulator front-end; runs entirely in the CMD_CLK domain.

Parameters:
LOCK_SYNCS, 4, consecutive aligned sync frames required to declare lock (1..15)
MISALIGN_LIMIT, 4, consecutive misaligned sync detections, with no aligned sync between them, that force loss of lock (1..15)
CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
CMD_CLK  in  1  command clock; all logic on rising edge
RST  in  1  asynchronous reset, active high
CNT_CLEAR  in  1  synchronous clear of all statistics counters
CMD_EN  in  1  line enable; a bit is sampled only when high
CMD_SERIAL_IN  in  1  serial command data, MSB first
LOCKED  out  1  frame alignment established
SYNC_STROBE  out  1  one-cycle pulse per aligned sync frame
TRIG_VALID  out  1  one-cycle pulse per valid trigger frame
TRIG_INDEX  out  4  trigger index 1..15, held until the next TRIG_VALID
DATA_VALID  out  1  one-cycle pulse per data frame
DATA_WORD  out  16  data frame contents, held until the next DATA_VALID
TRIG_ERR  out  1  one-cycle pulse: trigger symbol in upper byte, lower byte not 0x6A
SYNC_COUNT / TRIG_COUNT / DATA_COUNT / ERR_COUNT  out  CNT_WIDTH each  saturating event counters

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, FSM in HUNT. Reset mid-frame discards the partial frame.
- Sampling: on each edge with CMD_EN=1, shift register sr <= {sr[14:0], CMD_SERIAL_IN}. When CMD_EN=0, nothing shifts. CMD_EN falling in any state forces HUNT and clears the bit counter and lock counters.
- FSM states: HUNT, LOCKING, LOCKED.
- HUNT: on every sampled bit, compare the updated sr with 0x817E. On a match, set the bit counter so the next bit starts a frame, set aligned_cnt=1 and go to LOCKING. If LOCK_SYNCS=1, go directly to LOCKED instead.
- Framing (LOCKING and LOCKED): a 4-bit counter wraps 15->0. A frame completes on the edge where it wraps.
- LOCKING: at each frame boundary, a frame equal to 0x817E increments aligned_cnt. Reaching LOCK_SYNCS enters LOCKED. Any other frame returns to HUNT. No decode outputs are produced in LOCKING.
- LOCKED: LOCKED=1. Each completed frame is classified; outputs are registered and asserted on the edge after the frame's last bit (latency 1 cycle).
  - 0x817E: SYNC_STROBE.
  - Upper byte in the trigger table and lower byte 0x6A: TRIG_VALID, TRIG_INDEX = table index.
  - Upper byte in the trigger table and lower byte not 0x6A: TRIG_ERR, ERR_COUNT++.
  - Anything else: DATA_VALID, DATA_WORD = frame.
- Trigger table (index: symbol): 1:2B 2:2D 3:2E 4:33 5:35 6:36 7:39 8:3A 9:3C 10:4B 11:4D 12:4E 13:53 14:55 15:56.
- Misalignment (LOCKED only): sr==0x817E on a non-boundary bit increments misalign_cnt. An aligned sync frame clears misalign_cnt. When misalign_cnt reaches MISALIGN_LIMIT, drop to HUNT and clear LOCKED on the next edge.
- The transmitter always emits whole 16-bit frames; data frames are even byte pairs, and no byte-level realignment is performed.
- Counters: each increments by 1 per corresponding strobe and saturates at all ones. CNT_CLEAR has priority over a simultaneous increment. Counters are not cleared by loss of lock.

Decomposition:
- Shared package cmd_rd53_pkg holds SYNC_PATTERN=16'h817E, TAG_PATTERN=8'h6A, and the trigger symbol table with a lookup function symbol->index (0 = not a trigger). The transmitter and this receiver both use it.
- One natural sub-module: cmd_rd53_frame_decode, a combinational 16-bit frame -> {is_sync, is_trig, trig_idx, is_tag_err} classifier, instantiated once.

Test Plan:
- Reset, then send 4x 0x817E with CMD_EN=1 and 3 random leading bits -> LOCKED=1 one edge after the last bit of the 4th sync; SYNC_COUNT=0; no decode pulses before lock.
- Locked, then send 0x2B6A followed by 0x566A -> TRIG_VALID pulses with TRIG_INDEX=1, then 15; TRIG_COUNT=2; each pulse 1 cycle after the frame's last bit.
- Locked, then send 0x1234 and 0x817E -> DATA_VALID with DATA_WORD=0x1234, then SYNC_STROBE; DATA_COUNT=1, SYNC_COUNT=1.
- Locked, then send 0x2B00 -> TRIG_ERR pulse, ERR_COUNT=1, no TRIG_VALID or DATA_VALID.
- Locked, then insert 1 extra bit and send 4x 0x817E -> misaligned syncs counted, LOCKED=0 after the 4th; relock after 4 further aligned syncs.
- Drive SYNC_COUNT to 0xFFFF and send another sync -> counter stays 0xFFFF. Assert CNT_CLEAR together with a sync -> counter 0. Assert RST mid-frame -> all outputs 0 immediately, FSM in HUNT.
